// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: two-byte command sequencer driving an external 4-bit ALU
// and holding the error-qualified result until the consumer handshakes it.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    output logic [3:0] alu_op,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [7:0] alu_result,
    output logic [7:0] res_data,
    output logic       res_err,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] op_count
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OPND = 2'd1;
    localparam logic [1:0] EXEC = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] op_q, op_d, a_q, a_d, b_q, b_d;
    logic [7:0] data_q, data_d, cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       acc, div0, undef, done;

    assign cmd_ready = (state_q == IDLE) || (state_q == OPND);
    assign res_valid = state_q == HOLD;
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign res_data  = data_q;
    assign res_err   = err_q;
    assign op_count  = cnt_q;

    always_comb begin
        acc    = cmd_valid && cmd_ready;
        done   = res_valid && res_ready;
        div0   = (op_q == 4'd3) && (b_q == 4'd0);
        undef  = op_q >= 4'd13;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = acc ? OPND : IDLE;
            OPND:    state_d = acc ? EXEC : OPND;
            EXEC:    state_d = HOLD;
            default: state_d = done ? IDLE : HOLD;
        endcase
        op_d   = (acc && state_q == IDLE) ? cmd_data[7:4] : op_q;
        a_d    = (acc && state_q == OPND) ? cmd_data[7:4] : a_q;
        b_d    = (acc && state_q == OPND) ? cmd_data[3:0] : b_q;
        // error codes override whatever the ALU drives for these opcodes
        data_d = (state_q != EXEC) ? data_q : div0 ? 8'hFF : undef ? 8'h00 : alu_result;
        err_d  = (state_q != EXEC) ? err_q : (div0 || undef);
        cnt_d  = done ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: randomized commands against a spec-level result model,
// with a behavioural 4-bit ALU attached to the sequencer.
module tb_alu_seq_ctrl;
    logic       clk, rst, cmd_valid, cmd_ready, res_err, res_valid, res_ready;
    logic [7:0] cmd_data, alu_result, res_data, op_count;
    logic [3:0] alu_op, alu_a, alu_b;
    logic [7:0] exp_cnt;
    int         n_chk, n_pass;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .res_data(res_data), .res_err(res_err),
        .res_valid(res_valid), .res_ready(res_ready), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // garbage values for div-by-zero and undefined ops must never reach res_data
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [7:0] xa, xb;
        xa = {4'h0, a};
        xb = {4'h0, b};
        case (op)
            4'd0:    return xa + xb;
            4'd1:    return xa - xb;
            4'd2:    return xa * xb;
            4'd3:    return (b == 4'd0) ? 8'hAA : xa / xb;
            4'd4:    return xa & xb;
            4'd5:    return xa | xb;
            4'd6:    return xa ^ xb;
            4'd7:    return {4'h0, ~a};
            4'd8:    return xa << b[1:0];
            4'd9:    return xa >> b[1:0];
            4'd10:   return (a < b) ? 8'hFF : 8'h00;
            4'd11:   return {a, b};
            4'd12:   return {b, a};
            default: return 8'h5A;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                           input int gap, input int hold);
        logic [7:0] er;
        logic       ee;
        ee = (op == 4'd3 && b == 4'd0) || op >= 4'd13;
        er = (op == 4'd3 && b == 4'd0) ? 8'hFF : (op >= 4'd13) ? 8'h00 : alu_fn(op, a, b);
        chk("rdy_idle", cmd_ready, 1);
        cmd_valid = 1;
        cmd_data  = {op, 4'($urandom)};
        tick();
        chk("op_latch", alu_op, op);
        for (int i = 0; i < gap; i++) begin
            cmd_valid = 0;
            cmd_data  = 8'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            tick();
            chk("gap_op", alu_op, op);
            chk("gap_rdy", cmd_ready, 1);
            chk("gap_rv", res_valid, 0);
            chk("gap_cnt", op_count, exp_cnt);
        end
        cmd_valid = 1;
        cmd_data  = {a, b};
        res_ready = 0;
        tick();
        chk("exec_a", alu_a, a);
        chk("exec_b", alu_b, b);
        chk("exec_rv", res_valid, 0);
        chk("exec_rdy", cmd_ready, 0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_data  = 8'($urandom);
        res_ready = 1'($urandom_range(0, 1));
        tick();
        chk("hold_rv", res_valid, 1);
        chk("res_data", res_data, er);
        chk("res_err", res_err, ee);
        chk("hold_cnt", op_count, exp_cnt);
        for (int i = 0; i < hold; i++) begin
            res_ready = 0;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = 8'($urandom);
            tick();
            chk("bp_rv", res_valid, 1);
            chk("bp_data", res_data, er);
            chk("bp_err", res_err, ee);
            chk("bp_rdy", cmd_ready, 0);
            chk("bp_opnd", {alu_a, alu_b}, {a, b});
            chk("bp_op", alu_op, op);
        end
        res_ready = 1;
        cmd_valid = 1;
        cmd_data  = {~op, 4'h0};
        tick();
        exp_cnt++;
        chk("hs_rv", res_valid, 0);
        chk("hs_cnt", op_count, exp_cnt);
        chk("hs_op_kept", alu_op, op);
        chk("hs_rdy", cmd_ready, 1);
        res_ready = 0;
        cmd_valid = 0;
    endtask

    task automatic rst_pulse();
        rst = 1;
        #1;
        chk("rst_op", alu_op, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_data", res_data, 0);
        chk("rst_err", res_err, 0);
        chk("rst_rv", res_valid, 0);
        chk("rst_cnt", op_count, 0);
        chk("rst_rdy", cmd_ready, 1);
        tick();
        rst = 0;
        exp_cnt = 0;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        exp_cnt = 0;
        cmd_valid = 0;
        cmd_data = 0;
        res_ready = 0;
        rst = 0;
        #2;
        rst_pulse();
        tick();
        run_cmd(4'd0, 4'd9, 4'd7, 0, 0);
        chk("add_res", res_data, 8'h10);
        run_cmd(4'd3, 4'd5, 4'd0, 1, 1);
        run_cmd(4'd14, 4'd1, 4'd2, 2, 0);
        run_cmd(4'd10, 4'd3, 4'd5, 0, 10);
        // reset while waiting for the operand byte
        cmd_valid = 1;
        cmd_data  = 8'h70;
        tick();
        cmd_valid = 0;
        rst_pulse();
        // reset while a result is pending
        cmd_valid = 1;
        cmd_data  = 8'h20;
        tick();
        cmd_data  = 8'h33;
        tick();
        cmd_valid = 0;
        tick();
        chk("pre_rst_rv", res_valid, 1);
        rst_pulse();
        run_cmd(4'd4, 4'd12, 4'd6, 0, 0);
        chk("and_res", res_data, 8'h04);
        for (int k = 0; k < 255; k++)
            run_cmd(4'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                    $urandom_range(0, 2), $urandom_range(0, 2));
        chk("wrap_cnt", op_count, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
